// File: rtl/sng_et.sv
// Early-terminating stochastic number generator: N parallel SC bitstreams compared
// against a bit-reversed counter, with per-stream ones counts reported at end of run.

module sng_et_lane #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_bx,
  input  logic [W-1:0] i_s,
  input  logic [W-1:0] i_rev,
  output logic         o_bit
);
  assign o_bit = i_bx > (i_rev ^ i_s);
endmodule

module sng_et #(
  parameter int W        = 6,
  parameter int N        = 2,
  parameter int CORR     = 0,
  parameter int S_GROUPS = (CORR != 0) ? 1 : N
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [N-1:0][W-1:0]       i_bxs,
  input  logic [S_GROUPS-1:0][W-1:0] i_s,
  input  logic [W-1:0]              i_k_init,
  output logic                      o_ready,
  output logic                      o_bits_valid,
  output logic [N-1:0]              o_bits,
  output logic                      o_last,
  output logic                      o_done,
  output logic [N-1:0][W:0]         o_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                     r_state;
  logic [N-1:0][W-1:0]        r_bx;
  logic [S_GROUPS-1:0][W-1:0] r_s;
  logic [W:0]                 r_len;
  logic [W:0]                 r_t;
  logic [N-1:0][W:0]          r_acc;

  logic [W-1:0] w_rev;
  logic [N-1:0] w_bits;
  logic         w_end;

  // van der Corput sequence: reverse the W LSBs of the stream counter
  always_comb begin
    w_rev = '0;
    for (int b = 0; b < W; b++) w_rev[b] = r_t[W-1-b];
  end

  assign w_end = (r_t == r_len - (W+1)'(1));

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int G = (CORR != 0) ? 0 : i;
    sng_et_lane #(.W(W)) u_lane (
      .i_bx  (r_bx[i]),
      .i_s   (r_s[G]),
      .i_rev (w_rev),
      .o_bit (w_bits[i])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      o_ready      <= 1'b1;
      o_bits_valid <= 1'b0;
      o_bits       <= '0;
      o_last       <= 1'b0;
      o_done       <= 1'b0;
      o_cnt        <= '0;
      r_t          <= '0;
      r_acc        <= '0;
      r_bx         <= '0;
      r_s          <= '0;
      r_len        <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_bx    <= i_bxs;
            r_s     <= i_s;
            r_len   <= (i_k_init == '0) ? {1'b1, {W{1'b0}}} : {1'b0, i_k_init};
            r_t     <= '0;
            r_acc   <= '0;
            o_ready <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (i_abort) begin
            o_ready      <= 1'b1;
            o_bits_valid <= 1'b0;
            o_bits       <= '0;
            o_last       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            o_bits_valid <= 1'b1;
            o_bits       <= w_bits;
            o_last       <= w_end;
            r_t          <= r_t + (W+1)'(1);
            for (int i = 0; i < N; i++)
              r_acc[i] <= r_acc[i] + {{W{1'b0}}, w_bits[i]};
            if (w_end) r_state <= DONE;
          end
        end
        DONE: begin
          // abort while last is showing suppresses the done pulse
          o_bits_valid <= 1'b0;
          o_bits       <= '0;
          o_last       <= 1'b0;
          o_ready      <= 1'b1;
          r_state      <= IDLE;
          if (!i_abort) begin
            o_done <= 1'b1;
            o_cnt  <= r_acc;
          end
        end
        default: begin
          o_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sng_et.sv
// Directed bench for sng_et: an uncorrelated instance and a correlated (CORR=1) instance.

module tb_sng_et;
  localparam int W = 6;
  localparam int N = 2;
  localparam int MAXC = 80;

  logic clk, rst_n, abort, start0, start1;
  logic [N-1:0][W-1:0] bxs;
  logic [N-1:0][W-1:0] s0;
  logic [0:0][W-1:0]   s1;
  logic [W-1:0]        k;
  logic ready0, bv0, last0, done0, ready1, bv1, last1, done1;
  logic [N-1:0] bits0, bits1;
  logic [N-1:0][W:0] cnt0, cnt1;

  int n_chk = 0, n_fail = 0;
  int v_valid[0:MAXC], v_bits[0:MAXC], v_last[0:MAXC], v_done[0:MAXC], v_ready[0:MAXC];
  int a_nv, a_first, a_last, a_done_at, a_ndone, a_zero0, a_one1, a_viol;

  sng_et #(.W(W), .N(N), .CORR(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_abort(abort),
    .i_bxs(bxs), .i_s(s0), .i_k_init(k),
    .o_ready(ready0), .o_bits_valid(bv0), .o_bits(bits0), .o_last(last0),
    .o_done(done0), .o_cnt(cnt0));

  sng_et #(.W(W), .N(N), .CORR(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_abort(abort),
    .i_bxs(bxs), .i_s(s1), .i_k_init(k),
    .o_ready(ready1), .o_bits_valid(bv1), .o_bits(bits1), .o_last(last1),
    .o_done(done1), .o_cnt(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept a run, then sample ncyc cycles (#1 after each edge); optional
  // mid-run start poke, abort and reset at given cycle numbers (0 = none).
  task automatic collect(input int sel, input int ncyc, input int poke_at,
                         input int abort_at, input int rst_at);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == poke_at) begin
        bxs = {6'd50, 6'd50}; k = 6'd3;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      if (c == poke_at + 1) begin start0 = 1'b0; start1 = 1'b0; end
      abort = (c == abort_at);
      rst_n = !(c == rst_at);
      @(posedge clk); #1;
      v_valid[c] = (sel == 0) ? int'(bv0)    : int'(bv1);
      v_bits[c]  = (sel == 0) ? int'(bits0)  : int'(bits1);
      v_last[c]  = (sel == 0) ? int'(last0)  : int'(last1);
      v_done[c]  = (sel == 0) ? int'(done0)  : int'(done1);
      v_ready[c] = (sel == 0) ? int'(ready0) : int'(ready1);
    end
    abort = 1'b0; rst_n = 1'b1;
    a_nv = 0; a_first = -1; a_last = -1; a_done_at = -1; a_ndone = 0;
    a_zero0 = 0; a_one1 = 0; a_viol = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (v_valid[c] != 0) begin
        a_nv++;
        if (a_first < 0) a_first = c;
        if (v_bits[c][0] == 1'b0) a_zero0++;
        if (v_bits[c][1] == 1'b1) a_one1++;
        if (v_bits[c][1] && !v_bits[c][0]) a_viol++;
      end
      if (v_last[c] != 0) a_last = c;
      if (v_done[c] != 0) begin a_ndone++; a_done_at = c; end
    end
  endtask

  initial begin
    rst_n = 1'b0; abort = 1'b0; start0 = 1'b0; start1 = 1'b0;
    bxs = '0; s0 = '0; s1 = '0; k = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready0), 1);
    chk("rst_valid", int'(bv0), 0);
    chk("rst_bits", int'(bits0), 0);
    chk("rst_last", int'(last0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_cnt", int'(cnt0), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: full period, S=0
    bxs = {6'd12, 6'd24}; s0 = '0; k = 6'd0;
    collect(0, 70, 0, 0, 0);
    chk("t1_first", a_first, 1);
    chk("t1_nvalid", a_nv, 64);
    chk("t1_last", a_last, 64);
    chk("t1_done_at", a_done_at, 65);
    chk("t1_ndone", a_ndone, 1);
    chk("t1_ready_done", v_ready[65], 1);
    chk("t1_cnt1", int'(cnt0[1]), 12);
    chk("t1_cnt0", int'(cnt0[0]), 24);

    // T2: extreme binaries with nonzero offsets
    bxs = {6'd0, 6'd63}; s0 = {6'd5, 6'd9}; k = 6'd0;
    collect(0, 70, 0, 0, 0);
    chk("t2_zeros0", a_zero0, 1);
    chk("t2_ones1", a_one1, 0);
    chk("t2_cnt1", int'(cnt0[1]), 0);
    chk("t2_cnt0", int'(cnt0[0]), 63);

    // T3: early termination at k=4; R = 0,32,16,48
    bxs = {6'd12, 6'd24}; s0 = '0; k = 6'd4;
    collect(0, 8, 0, 0, 0);
    chk("t3_bits_c1", v_bits[1], 3);
    chk("t3_bits_c2", v_bits[2], 0);
    chk("t3_bits_c3", v_bits[3], 1);
    chk("t3_bits_c4", v_bits[4], 0);
    chk("t3_nvalid", a_nv, 4);
    chk("t3_last", a_last, 4);
    chk("t3_done_at", a_done_at, 5);
    chk("t3_cnt1", int'(cnt0[1]), 1);
    chk("t3_cnt0", int'(cnt0[0]), 2);

    // T4: correlated instance
    bxs = {6'd12, 6'd24}; s1 = '0; k = 6'd0;
    collect(1, 70, 0, 0, 0);
    chk("t4_implication", a_viol, 0);
    chk("t4_nvalid", a_nv, 64);
    chk("t4_cnt1", int'(cnt1[1]), 12);
    chk("t4_cnt0", int'(cnt1[0]), 24);

    // T5a: start pulsed mid-run with new inputs is ignored
    bxs = {6'd12, 6'd24}; s0 = '0; k = 6'd0;
    collect(0, 70, 10, 0, 0);
    chk("t5_nvalid", a_nv, 64);
    chk("t5_ndone", a_ndone, 1);
    chk("t5_ready_poke", v_ready[10], 0);
    chk("t5_cnt1", int'(cnt0[1]), 12);
    chk("t5_cnt0", int'(cnt0[0]), 24);

    // T5b: abort at cycle 20 -> idle, no done, cnt held
    bxs = {6'd3, 6'd7}; k = 6'd0;
    collect(0, 70, 0, 20, 0);
    chk("t5_abort_nvalid", a_nv, 19);
    chk("t5_abort_valid20", v_valid[20], 0);
    chk("t5_abort_ready20", v_ready[20], 1);
    chk("t5_abort_ndone", a_ndone, 0);
    chk("t5_abort_nolast", a_last, -1);
    chk("t5_abort_cnt1", int'(cnt0[1]), 12);
    chk("t5_abort_cnt0", int'(cnt0[0]), 24);

    // T6: reset at cycle 30 of a full run, then a fresh T1 run
    bxs = {6'd12, 6'd24}; s0 = '0; k = 6'd0;
    collect(0, 70, 0, 0, 30);
    chk("t6_ready30", v_ready[30], 1);
    chk("t6_valid30", v_valid[30], 0);
    chk("t6_bits30", v_bits[30], 0);
    chk("t6_ndone", a_ndone, 0);
    chk("t6_cnt", int'(cnt0), 0);
    collect(0, 70, 0, 0, 0);
    chk("t6_fresh_nvalid", a_nv, 64);
    chk("t6_fresh_cnt1", int'(cnt0[1]), 12);
    chk("t6_fresh_cnt0", int'(cnt0[0]), 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
